// File: rtl/commit_rob.sv
// commit_rob: in-order commit buffer with multi-port out-of-order completion and squash.
module commit_rob #(
    parameter int p_seq_num_bits   = 5,
    parameter int p_num_pipes      = 3,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              alloc_val,
    output logic                                              alloc_rdy,
    output logic [p_seq_num_bits-1:0]                         alloc_seq_num,
    input  logic [p_num_pipes-1:0]                            cmpl_val,
    input  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]        cmpl_seq_num,
    input  logic [p_num_pipes-1:0][31:0]                      cmpl_pc,
    input  logic [p_num_pipes-1:0][4:0]                       cmpl_waddr,
    input  logic [p_num_pipes-1:0][p_phys_addr_bits-1:0]      cmpl_preg,
    input  logic [p_num_pipes-1:0][31:0]                      cmpl_wdata,
    input  logic [p_num_pipes-1:0]                            cmpl_wen,
    input  logic                                              squash_val,
    input  logic [p_seq_num_bits-1:0]                         squash_seq_num,
    output logic                                              commit_val,
    output logic [p_seq_num_bits-1:0]                         commit_seq_num,
    output logic [31:0]                                       commit_pc,
    output logic [4:0]                                        commit_waddr,
    output logic [p_phys_addr_bits-1:0]                       commit_preg,
    output logic [31:0]                                       commit_wdata,
    output logic                                              commit_wen,
    output logic [p_seq_num_bits:0]                           occupancy
);
    localparam int SN = p_seq_num_bits;
    localparam int CW = p_seq_num_bits + 1;
    localparam int D  = 1 << p_seq_num_bits;

    logic [SN-1:0]               head, tail, sq_age;
    logic [CW-1:0]               count, next_count;
    logic [D-1:0]                alloc_q, done_q, kill, wen_q;
    logic [31:0]                 pc_q    [D];
    logic [4:0]                  waddr_q [D];
    logic [p_phys_addr_bits-1:0] preg_q  [D];
    logic [31:0]                 wdata_q [D];
    logic [p_num_pipes-1:0]      win;
    logic                        sq, do_alloc, do_commit;

    always_comb begin
        sq_age    = squash_seq_num - head;
        // a squash naming an entry outside the live window is ignored
        sq        = squash_val && ({1'b0, sq_age} < count);
        do_commit = alloc_q[head] && done_q[head];
        do_alloc  = alloc_val && alloc_rdy && !sq;
        for (int e = 0; e < D; e++)
            kill[e] = sq && alloc_q[e] && ((SN'(e) - head) > sq_age);
        for (int i = 0; i < p_num_pipes; i++) begin
            win[i] = cmpl_val[i] && alloc_q[cmpl_seq_num[i]] && !done_q[cmpl_seq_num[i]]
                     && !kill[cmpl_seq_num[i]];
            for (int j = 0; j < i; j++)
                if (cmpl_val[j] && cmpl_seq_num[j] == cmpl_seq_num[i]) win[i] = 1'b0;
        end
        next_count = sq ? CW'(sq_age) + CW'(1) - CW'(do_commit)
                        : count + CW'(do_alloc) - CW'(do_commit);
    end

    assign alloc_rdy      = count != CW'(D);
    assign alloc_seq_num  = tail;
    assign occupancy      = count;
    assign commit_val     = do_commit;
    assign commit_seq_num = do_commit ? head : '0;
    assign commit_pc      = do_commit ? pc_q[head] : '0;
    assign commit_waddr   = do_commit ? waddr_q[head] : '0;
    assign commit_preg    = do_commit ? preg_q[head] : '0;
    assign commit_wdata   = do_commit ? wdata_q[head] : '0;
    assign commit_wen     = do_commit && wen_q[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            alloc_q <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < p_num_pipes; i++)
                if (win[i]) done_q[cmpl_seq_num[i]] <= 1'b1;
            if (do_alloc) begin
                alloc_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
                tail          <= tail + SN'(1);
            end
            if (do_commit) begin
                alloc_q[head] <= 1'b0;
                done_q[head]  <= 1'b0;
                head          <= head + SN'(1);
            end
            if (sq) begin
                for (int e = 0; e < D; e++)
                    if (kill[e]) begin
                        alloc_q[e] <= 1'b0;
                        done_q[e]  <= 1'b0;
                    end
                tail <= squash_seq_num + SN'(1);
            end
            count <= next_count;
        end
    end

    // payload needs no reset: it is only visible while its entry is complete
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_num_pipes; i++)
            if (win[i] && !rst) begin
                pc_q[cmpl_seq_num[i]]    <= cmpl_pc[i];
                waddr_q[cmpl_seq_num[i]] <= cmpl_waddr[i];
                preg_q[cmpl_seq_num[i]]  <= cmpl_preg[i];
                wdata_q[cmpl_seq_num[i]] <= cmpl_wdata[i];
                wen_q[cmpl_seq_num[i]]   <= cmpl_wen[i];
            end
    end
endmodule

// File: doc/commit_rob.md
COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 SHALL have parameter p_seq_num_bits, default 5, sequence-number width; depth D = 2**p_seq_num_bits.
REQ-002 SHALL have parameter p_num_pipes, default 3, number of completion ports.
REQ-003 SHALL have parameter p_phys_addr_bits, default 6, physical register address width.
REQ-004 SHALL have port clk  input  1  clock; single clock domain, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port alloc_val  input  1  request to allocate next program-order entry.
REQ-007 SHALL have port alloc_rdy  output  1  entry available.
REQ-008 SHALL have port alloc_seq_num  output  p_seq_num_bits  seq num granted on alloc handshake (equals tail).
REQ-009 SHALL have port cmpl_val  input  p_num_pipes  per-port completion valid; no ready, always accepted.
REQ-010 SHALL have ports cmpl_seq_num (p_seq_num_bits), cmpl_pc (32), cmpl_waddr (5), cmpl_preg (p_phys_addr_bits), cmpl_wdata (32), cmpl_wen (1)  input  per port, packed arrays of p_num_pipes  completion payload.
REQ-011 SHALL have port squash_val  input  1  discard all entries younger than squash_seq_num.
REQ-012 SHALL have port squash_seq_num  input  p_seq_num_bits  youngest surviving entry.
REQ-013 SHALL have ports commit_val (1), commit_seq_num, commit_pc, commit_waddr, commit_preg, commit_wdata, commit_wen  output  in-order commit notification, same widths as completion payload; no backpressure.
REQ-014 SHALL have port occupancy  output  p_seq_num_bits+1  number of allocated entries.

Function
REQ-015 SHALL hold head, tail (p_seq_num_bits, wrap modulo D) and count (0..D); per-entry allocated and complete bits plus payload storage.
REQ-016 SHALL drive alloc_rdy = (count < D) from registered count only; no same-cycle bypass of a commit.
REQ-017 SHALL on alloc_val && alloc_rdy mark entry[tail] allocated, not complete, and advance tail by 1 at the edge.
REQ-018 SHALL on cmpl_val[i] for an allocated, not-complete entry write payload and set complete at the edge.
REQ-019 SHALL ignore completions targeting unallocated or already-complete entries.
REQ-020 SHALL, when two ports complete the same seq num in one cycle, accept the lowest-indexed port only.
REQ-021 SHALL assert commit_val combinationally when entry[head] is allocated and complete, driving that entry's payload; minimum completion-to-commit latency is 1 cycle.
REQ-022 SHALL commit at most one entry per cycle; on commit, clear entry[head] and advance head by 1 at the edge.
REQ-023 SHALL on squash_val clear every allocated entry strictly younger than squash_seq_num (age relative to head), set tail = squash_seq_num+1, recompute count.
REQ-024 SHALL give squash priority over a same-cycle alloc (alloc not performed, alloc_rdy still visible); a same-cycle commit of head still occurs.
REQ-025 SHALL drop same-cycle completions to entries being squashed.
REQ-026 SHALL update count as +1 alloc, -1 commit, net 0 when both; count never exceeds D or goes below 0.
REQ-027 SHALL handle head/tail wrap from D-1 to 0 without loss of ordering.

Reset
REQ-028 SHALL on rst set head=0, tail=0, count=0, clear all allocated/complete bits; outputs: alloc_rdy=1, alloc_seq_num=0, commit_val=0, occupancy=0, commit payload 0.
REQ-029 SHALL let rst override alloc, completion, squash and commit in the same cycle, including mid-operation with a full buffer.

Verification
REQ-030 SHALL cover: alloc seqs 0,1,2; complete 2 then 1 then 0 on ports 2,1,0 -> commit_val in order 0,1,2, one per cycle, first commit the cycle after seq 0 completes.
REQ-031 SHALL cover: default D=32, allocate 32 without commit -> alloc_rdy=0, occupancy=32; complete and commit seq 0 same cycle as alloc_val -> alloc refused that cycle, accepted next with alloc_seq_num=0.
REQ-032 SHALL cover: ports 0 and 1 complete seq 5 same cycle with wdata 0xAAAA and 0xBBBB -> commit of seq 5 shows 0xAAAA.
REQ-033 SHALL cover: allocate 0..9, squash_seq_num=4 with alloc_val high -> occupancy=5, next alloc_seq_num=5; later completion to seq 7 ignored.
REQ-034 SHALL cover: run 70 alloc/complete/commit cycles -> seq nums wrap 31->0, commits strictly in order, occupancy never exceeds 32.
REQ-035 SHALL cover: rst asserted with 12 entries, 3 complete -> next cycle commit_val=0, occupancy=0, alloc_seq_num=0.
